// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Contents:
//   SNT/WNT/WT/ST   - 2-bit saturating counter encodings
//   TAG_MAX_W       - storage width of the tag field (fits any IDX_W >= 0)
//   bp_entry_t      - one table entry {valid, tag, target, ctr}
//   sat_update()    - saturating counter step towards the resolved outcome
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Tags are stored zero-extended to pc[31:2] width; only TAG_W bits are live.
    localparam int unsigned TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } bp_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle between the pipeline and the branch predictor.
// Fetch side : if_pc -> pred_hit, pred_taken, pred_next_pc
// Execute side: ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
//               ex_pred_taken, ex_pred_target -> mispredict, redirect_pc
// Optional (BP_STATS_EN): stat_branches, stat_mispredicts
// Modports: master = pipeline, slave = predictor.
interface branch_predictor_if;

    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    modport master (
        output if_pc,
        input  pred_hit, pred_taken, pred_next_pc,
        output ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target,
        input  mispredict, redirect_pc
`ifdef BP_STATS_EN
        ,
        input  stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  if_pc,
        output pred_hit, pred_taken, pred_next_pc,
        input  ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target,
        output mispredict, redirect_pc
`ifdef BP_STATS_EN
        ,
        output stat_branches, stat_mispredicts
`endif
    );

endinterface

// File: rtl/bp_resolve.sv
// Combinational mispredict / redirect generation from the execute-stage outcome.
// Inputs : rst_i (gates mispredict), ex_* resolved and carried-down prediction fields
// Outputs: mispredict_o, redirect_pc_o (ex_pc+4 whenever no target redirect applies)
module bp_resolve (
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_is_jump_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o
);

    logic        is_ctrl;
    logic [31:0] pc_plus4;

    assign is_ctrl  = ex_is_branch_i | ex_is_jump_i;
    assign pc_plus4 = ex_pc_i + 32'd4;

    always_comb begin
        mispredict_o = 1'b0;
        if (ex_valid_i && !rst_i) begin
            if (is_ctrl) begin
                mispredict_o = (ex_taken_i != ex_pred_taken_i) ||
                               (ex_taken_i && (ex_target_i != ex_pred_target_i));
            end else begin
                // A non-control instruction should never have been predicted taken.
                mispredict_o = ex_pred_taken_i;
            end
        end
    end

    assign redirect_pc_o = (mispredict_o && is_ctrl && ex_taken_i) ? ex_target_i : pc_plus4;

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped table of 2-bit counters plus BTB targets.
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   bp        - branch_predictor_if.slave (fetch lookup, execute training, redirect)
// Lookup is combinational from the registered table (no write-through); training
// writes at the next rising edge. Optional macro BP_STATS_EN adds branch and
// mispredict counters on the interface.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 32 - IDX_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);

    localparam int unsigned Entries = 2 ** IDX_W;

    bp_entry_t tbl_q [Entries];

    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc);
        logic [TAG_MAX_W-1:0] t;
        t = '0;
        t[TAG_W-1:0] = pc[31 -: TAG_W];
        return t;
    endfunction

    // ---------------- Lookup ----------------
    logic [IDX_W-1:0] if_idx;
    bp_entry_t        rd_entry;
    logic             rd_hit;

    assign if_idx   = bp.if_pc[IDX_W+1:2];
    assign rd_entry = tbl_q[if_idx];
    assign rd_hit   = rd_entry.valid && (rd_entry.tag == tag_of(bp.if_pc));

    assign bp.pred_hit     = rd_hit;
    assign bp.pred_taken   = rd_hit & rd_entry.ctr[1];
    assign bp.pred_next_pc = (rd_hit & rd_entry.ctr[1]) ? rd_entry.target
                                                        : bp.if_pc + 32'd4;

    // ---------------- Training ----------------
    logic [IDX_W-1:0] upd_idx;
    bp_entry_t        old_entry;
    bp_entry_t        upd_entry;
    logic             upd_en;
    logic             ex_hit;

    assign upd_idx   = bp.ex_pc[IDX_W+1:2];
    assign old_entry = tbl_q[upd_idx];
    assign ex_hit    = old_entry.valid && (old_entry.tag == tag_of(bp.ex_pc));

    always_comb begin
        upd_en    = 1'b0;
        upd_entry = old_entry;
        if (bp.ex_valid) begin
            if (bp.ex_is_jump) begin
                upd_en    = 1'b1;
                upd_entry = '{valid: 1'b1, tag: tag_of(bp.ex_pc), target: bp.ex_target, ctr: ST};
            end else if (bp.ex_is_branch) begin
                if (ex_hit) begin
                    upd_en        = 1'b1;
                    upd_entry.ctr = sat_update(old_entry.ctr, bp.ex_taken);
                    if (bp.ex_taken) begin
                        upd_entry.target = bp.ex_target;
                    end
                end else if (bp.ex_taken) begin
                    // Taken miss replaces whatever lives at this index.
                    upd_en    = 1'b1;
                    upd_entry = '{valid: 1'b1, tag: tag_of(bp.ex_pc), target: bp.ex_target,
                                  ctr: WT};
                end
            end else if (ex_hit) begin
                // Entry matches an instruction that is not control flow: stale, drop it.
                upd_en          = 1'b1;
                upd_entry.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (upd_en) begin
            tbl_q[upd_idx] <= upd_entry;
        end
    end

    // ---------------- Resolve ----------------
    logic        misp;
    logic [31:0] redir;

    bp_resolve u_resolve (
        .rst_i            (rst),
        .ex_valid_i       (bp.ex_valid),
        .ex_pc_i          (bp.ex_pc),
        .ex_is_branch_i   (bp.ex_is_branch),
        .ex_is_jump_i     (bp.ex_is_jump),
        .ex_taken_i       (bp.ex_taken),
        .ex_target_i      (bp.ex_target),
        .ex_pred_taken_i  (bp.ex_pred_taken),
        .ex_pred_target_i (bp.ex_pred_target),
        .mispredict_o     (misp),
        .redirect_pc_o    (redir)
    );

    assign bp.mispredict  = misp;
    assign bp.redirect_pc = redir;

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jump)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (misp) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table plus randomized
// traffic checked against a behavioural predictor model.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if bp ();

    branch_predictor #(.IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        br;
        logic        jmp;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic [31:0] ifpc;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_npc;
        logic        e_mp;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ev, input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt, input logic [31:0] ifpc, input logic e_hit,
                       input logic e_tk, input logic [31:0] e_npc, input logic e_mp,
                       input logic [31:0] e_rd);
        vec_t v;
        v = '{ev, pc, br, jmp, tk, tgt, ptk, ptgt, ifpc, e_hit, e_tk, e_npc, e_mp, e_rd};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ev, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt, input logic [31:0] ifpc);
        bp.ex_valid       = ev;
        bp.ex_pc          = pc;
        bp.ex_is_branch   = br;
        bp.ex_is_jump     = jmp;
        bp.ex_taken       = tk;
        bp.ex_target      = tgt;
        bp.ex_pred_taken  = ptk;
        bp.ex_pred_target = ptgt;
        bp.if_pc          = ifpc;
    endtask

    task automatic idle(input logic [31:0] ifpc);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ifpc);
    endtask

    // ---------------- Behavioural model ----------------
    // One slot per index; each slot remembers which PC line it holds.
    bit          m_valid [16];
    logic [31:0] m_line  [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s;
        s = slot(pc);
        return m_valid[s] && (m_line[s] == (pc & 32'hFFFF_FFFC));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_line[i]  = 32'h0;
            m_tgt[i]   = 32'h0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic m_train(input logic [31:0] pc, input int kind, input logic tk,
                           input logic [31:0] tgt);
        int s;
        bit h;
        s = slot(pc);
        h = m_hit(pc);
        if (kind == 2) begin
            m_valid[s] = 1; m_line[s] = pc & 32'hFFFF_FFFC; m_tgt[s] = tgt; m_ctr[s] = 3;
        end else if (kind == 1) begin
            if (h) begin
                if (tk) begin
                    m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = tgt;
                end else begin
                    m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (tk) begin
                m_valid[s] = 1; m_line[s] = pc & 32'hFFFF_FFFC; m_tgt[s] = tgt; m_ctr[s] = 2;
            end
        end else if (h) begin
            m_valid[s] = 0;
        end
    endtask

    logic [31:0] pc_pool [8];
    int exp_br;
    int exp_mp;

    initial begin
        pc_pool[0] = 32'h0000_0200; pc_pool[1] = 32'h0000_0240; pc_pool[2] = 32'h0000_0300;
        pc_pool[3] = 32'h0000_0104; pc_pool[4] = 32'h0000_0108; pc_pool[5] = 32'hFFFF_FFFC;
        pc_pool[6] = 32'h0000_1000; pc_pool[7] = 32'h0000_2040;

        // ---------------- Reset ----------------
        rst = 1'b1;
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 32'h100);
        #2;
        chk("rst_hit", 32'(bp.pred_hit), 32'h0);
        chk("rst_taken", 32'(bp.pred_taken), 32'h0);
        chk("rst_next", bp.pred_next_pc, 32'h104);
        chk("rst_misp_gated", 32'(bp.mispredict), 32'h0);
        @(negedge clk);
        idle(32'h100);
        rst = 1'b0;

        // ---------------- Directed table ----------------
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h100, 0, 0, 32'h104, 0, 32'h4);
        add(1, 32'h200, 1, 0, 1, 32'h80, 0, 32'h204, 32'h200, 0, 0, 32'h204, 1, 32'h80);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h200, 1, 1, 32'h80, 0, 32'h4);
        for (int i = 0; i < 3; i++)
            add(1, 32'h200, 1, 0, 1, 32'h80, 1, 32'h80, 32'h200, 1, 1, 32'h80, 0, 32'h204);
        add(1, 32'h200, 1, 0, 0, 32'h80, 1, 32'h80, 32'h200, 1, 1, 32'h80, 1, 32'h204);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h200, 1, 1, 32'h80, 0, 32'h4);
        add(1, 32'h200, 1, 0, 0, 32'h80, 1, 32'h80, 32'h200, 1, 1, 32'h80, 1, 32'h204);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h200, 1, 0, 32'h204, 0, 32'h4);
        add(1, 32'h40, 0, 1, 1, 32'h1000, 0, 32'h44, 32'h40, 0, 0, 32'h44, 1, 32'h1000);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h40, 1, 1, 32'h1000, 0, 32'h4);
        add(1, 32'h80, 0, 1, 1, 32'h2000, 0, 32'h84, 32'h40, 1, 1, 32'h1000, 1, 32'h2000);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h40, 0, 0, 32'h44, 0, 32'h4);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h80, 1, 1, 32'h2000, 0, 32'h4);
        add(1, 32'h300, 1, 0, 1, 32'h500, 0, 32'h304, 32'h300, 0, 0, 32'h304, 1, 32'h500);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h300, 1, 1, 32'h500, 0, 32'h4);
        add(1, 32'h300, 0, 0, 0, 32'h0, 1, 32'h500, 32'h300, 1, 1, 32'h500, 1, 32'h304);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h300, 0, 0, 32'h304, 0, 32'h4);
        add(1, 32'hFFFF_FFFC, 1, 0, 0, 32'h10, 1, 32'h10, 32'hFFFF_FFFC, 0, 0, 32'h0, 1,
            32'h0);
        add(1, 32'h104, 0, 1, 1, 32'h900, 1, 32'h900, 32'h104, 0, 0, 32'h108, 0, 32'h108);
        add(1, 32'h104, 0, 1, 1, 32'hA00, 1, 32'h900, 32'h104, 1, 1, 32'h900, 1, 32'hA00);
        add(0, 32'h104, 0, 0, 0, 32'h0, 1, 32'h0, 32'h104, 1, 1, 32'hA00, 0, 32'h108);

        exp_br = 0;
        exp_mp = 0;
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].ev, vecs[i].pc, vecs[i].br, vecs[i].jmp, vecs[i].tk, vecs[i].tgt,
                  vecs[i].ptk, vecs[i].ptgt, vecs[i].ifpc);
            @(negedge clk);
            chk($sformatf("v%0d_hit", i), 32'(bp.pred_hit), 32'(vecs[i].e_hit));
            chk($sformatf("v%0d_taken", i), 32'(bp.pred_taken), 32'(vecs[i].e_tk));
            chk($sformatf("v%0d_next", i), bp.pred_next_pc, vecs[i].e_npc);
            chk($sformatf("v%0d_misp", i), 32'(bp.mispredict), 32'(vecs[i].e_mp));
            chk($sformatf("v%0d_redir", i), bp.redirect_pc, vecs[i].e_rd);
            if (vecs[i].ev && (vecs[i].br || vecs[i].jmp)) exp_br++;
            if (vecs[i].e_mp) exp_mp++;
        end
        @(posedge clk);
        #1;
        idle(32'h104);
`ifdef BP_STATS_EN
        chk("stat_branches", bp.stat_branches, 32'(exp_br));
        chk("stat_mispredicts", bp.stat_mispredicts, 32'(exp_mp));
`endif

        // ---------------- Randomized traffic vs model ----------------
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_hit", 32'(bp.pred_hit), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        exp_br = 0;
        exp_mp = 0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, tgt, ifpc, ptgt, e_rd;
            logic        ev, tk, ptk, e_mp, ctrl;
            int          kind;
            @(posedge clk);
            #1;
            ev   = ($urandom_range(0, 7) != 0);
            pc   = pc_pool[$urandom_range(0, 7)];
            kind = int'($urandom_range(0, 2));
            tgt  = $urandom_range(0, 3) == 0 ? ($urandom & 32'hFFFF_FFFC)
                                             : (32'h4000 + 32'h40 * $urandom_range(0, 2));
            tk   = (kind == 2) ? 1'b1 : (kind == 1 ? 1'($urandom_range(0, 1)) : 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = ptk ? tgt : pc + 32'd4;
            end else begin
                ptk  = m_taken(pc);
                ptgt = m_next(pc);
            end
            ifpc = ($urandom_range(0, 1) == 0) ? pc : pc_pool[$urandom_range(0, 7)];
            drive(ev, pc, kind == 1, kind == 2, tk, tgt, ptk, ptgt, ifpc);
            ctrl = (kind != 0);
            if (!ev) e_mp = 1'b0;
            else if (ctrl) e_mp = (tk != ptk) || (tk && tgt != ptgt);
            else e_mp = ptk;
            e_rd = (e_mp && ctrl && tk) ? tgt : pc + 32'd4;
            @(negedge clk);
            chk($sformatf("r%0d_hit", n), 32'(bp.pred_hit), 32'(m_hit(ifpc)));
            chk($sformatf("r%0d_taken", n), 32'(bp.pred_taken), 32'(m_taken(ifpc)));
            chk($sformatf("r%0d_next", n), bp.pred_next_pc, m_next(ifpc));
            chk($sformatf("r%0d_misp", n), 32'(bp.mispredict), 32'(e_mp));
            chk($sformatf("r%0d_redir", n), bp.redirect_pc, e_rd);
            if (ev) m_train(pc, kind, tk, tgt);
            if (ev && ctrl) exp_br++;
            if (e_mp) exp_mp++;
        end
        @(posedge clk);
        #1;
        idle(32'h104);
`ifdef BP_STATS_EN
        chk("rstat_branches", bp.stat_branches, 32'(exp_br));
        chk("rstat_mispredicts", bp.stat_mispredicts, 32'(exp_mp));
`endif

        // ---------------- Reset mid-training ----------------
        drive(1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h700, 1'b0, 32'h108, 32'h104);
        @(posedge clk);
        #1;
        idle(32'h104);
        @(negedge clk);
        chk("pre_rst_hit", 32'(bp.pred_hit), 32'h1);
        chk("pre_rst_next", bp.pred_next_pc, 32'h700);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_hit", 32'(bp.pred_hit), 32'h0);
        chk("async_rst_next", bp.pred_next_pc, 32'h108);
`ifdef BP_STATS_EN
        chk("async_rst_stat", bp.stat_branches, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_hit", 32'(bp.pred_hit), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
